// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch sequencer: state encoding and default sizes.
package fetch_ctrl_pkg;

  localparam int unsigned PC_W_DEF     = 10;
  localparam int unsigned INSTR_W_DEF  = 16;
  localparam int unsigned RESET_PC_DEF = 0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    DISCARD = 2'd2,
    HALT    = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_redirect_sel.sv
// Redirect source arbitration: a jump always wins over a same-cycle branch.
module fetch_redirect_sel
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned PC_W = PC_W_DEF
) (
  input  logic            jump,
  input  logic            branch,
  input  logic [PC_W-1:0] jump_target,
  input  logic [PC_W-1:0] branch_addr,
  output logic            redir,
  output logic [PC_W-1:0] tgt
);

  always_comb begin
    redir = jump | branch;
    tgt   = jump ? jump_target : branch_addr;
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, drives a single-outstanding imem req/ack port and
// hands fetched words to decode, discarding wrong-path responses after redirects/halts.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned PC_W     = PC_W_DEF,
  parameter int unsigned INSTR_W  = INSTR_W_DEF,
  parameter int unsigned RESET_PC = RESET_PC_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               branch,
  input  logic [PC_W-1:0]    branch_addr,
  input  logic               jump,
  input  logic [PC_W-1:0]    jump_target,
  input  logic               halt_req,
  input  logic               resume,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc,
  output logic [PC_W-1:0]    pc_out,
  output logic               redirect_flush,
  output logic               halted
);

  localparam logic [PC_W-1:0] PC_RST = PC_W'(RESET_PC);

  fetch_state_t       state, state_nxt;
  logic [PC_W-1:0]    pc, pc_nxt, pending, pending_nxt, instr_pc_nxt, dest;
  logic [INSTR_W-1:0] instr_nxt;
  logic               halt_pend, halt_pend_nxt, instr_valid_nxt, flush_nxt;
  logic               redir;
  logic [PC_W-1:0]    tgt;

  fetch_redirect_sel #(.PC_W(PC_W)) u_redirect_sel (
    .jump        (jump),
    .branch      (branch),
    .jump_target (jump_target),
    .branch_addr (branch_addr),
    .redir       (redir),
    .tgt         (tgt)
  );

  // The request address is always the PC: entering DISCARD parks the new target in
  // 'pending', so the outstanding address stays put until its ack arrives.
  assign imem_addr = pc;
  assign pc_out    = pc;
  assign halted    = (state == HALT);

  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    pending_nxt     = pending;
    halt_pend_nxt   = halt_pend;
    instr_nxt       = instr;
    instr_pc_nxt    = instr_pc;
    instr_valid_nxt = instr_valid;
    flush_nxt       = 1'b0;
    imem_req        = 1'b0;
    dest            = redir ? tgt : pc;

    case (state)
      IDLE: state_nxt = FETCH;

      FETCH: begin
        imem_req = !(instr_valid && stall);
        if (redir || halt_req) begin
          instr_valid_nxt = 1'b0;
          flush_nxt       = 1'b1;
          if (imem_req && !imem_ack) begin
            pending_nxt   = dest;
            halt_pend_nxt = halt_req;
            state_nxt     = DISCARD;
          end else begin
            pc_nxt    = dest;
            state_nxt = halt_req ? HALT : FETCH;
          end
        end else if (imem_req && imem_ack) begin
          instr_nxt       = imem_rdata;
          instr_pc_nxt    = pc;
          instr_valid_nxt = 1'b1;
          pc_nxt          = pc + PC_W'(1);
        end else if (!stall) begin
          instr_valid_nxt = 1'b0;
        end
      end

      DISCARD: begin
        imem_req = 1'b1;
        if (redir) pending_nxt = tgt;
        if (halt_req) halt_pend_nxt = 1'b1;
        if (redir || halt_req) begin
          instr_valid_nxt = 1'b0;
          flush_nxt       = 1'b1;
        end
        // A redirect arriving with the ack still takes effect on this exit.
        if (imem_ack) begin
          pc_nxt        = pending_nxt;
          state_nxt     = halt_pend_nxt ? HALT : FETCH;
          halt_pend_nxt = 1'b0;
        end
      end

      HALT: begin
        if (redir) pc_nxt = tgt;
        if (resume) state_nxt = FETCH;
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      pc             <= PC_RST;
      pending        <= PC_RST;
      halt_pend      <= 1'b0;
      instr          <= '0;
      instr_pc       <= '0;
      instr_valid    <= 1'b0;
      redirect_flush <= 1'b0;
    end else begin
      state          <= state_nxt;
      pc             <= pc_nxt;
      pending        <= pending_nxt;
      halt_pend      <= halt_pend_nxt;
      instr          <= instr_nxt;
      instr_pc       <= instr_pc_nxt;
      instr_valid    <= instr_valid_nxt;
      redirect_flush <= flush_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed vectors with literal expectations, plus a per-cycle
// behavioural model compared against every output.
module tb_fetch_ctrl;

  localparam int unsigned PC_W    = 10;
  localparam int unsigned INSTR_W = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic stall = 1'b0, branch = 1'b0, jump = 1'b0;
  logic halt_req = 1'b0, resume = 1'b0, imem_ack = 1'b0;
  logic [PC_W-1:0] branch_addr = '0, jump_target = '0;
  logic imem_req, instr_valid, redirect_flush, halted;
  logic [PC_W-1:0] imem_addr, instr_pc, pc_out;
  logic [INSTR_W-1:0] imem_rdata, instr;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  // Memory returns a word that encodes its own address.
  assign imem_rdata = 16'hA000 ^ {6'b0, imem_addr};

  fetch_ctrl #(.PC_W(PC_W), .INSTR_W(INSTR_W), .RESET_PC(0)) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .branch         (branch),
    .branch_addr    (branch_addr),
    .jump           (jump),
    .jump_target    (jump_target),
    .halt_req       (halt_req),
    .resume         (resume),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .pc_out         (pc_out),
    .redirect_flush (redirect_flush),
    .halted         (halted)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Inputs change at the falling edge; outputs are observed 3 time units later.
  task automatic drive(input logic rs, input logic st, input logic br, input logic [PC_W-1:0] ba,
                       input logic jp, input logic [PC_W-1:0] jt, input logic hr,
                       input logic re, input logic ak);
    @(negedge clk);
    reset = rs; stall = st; branch = br; branch_addr = ba; jump = jp;
    jump_target = jt; halt_req = hr; resume = re; imem_ack = ak;
    #3;
  endtask

  // Model: flags 'boot' (first cycle after reset), 'stop' (halted), 'drain' (waiting
  // out a wrong-path response). Checked before advancing to the next cycle.
  initial begin : model
    logic boot, stop, drain, stop_after, m_valid, m_flush, nflush, rq, rd;
    logic [PC_W-1:0] m_pc, after, m_ipc, dest, tg;
    logic [INSTR_W-1:0] m_instr;
    forever begin
      @(negedge clk); #2;
      if (!reset) begin
        boot = 1'b1; stop = 1'b0; drain = 1'b0; stop_after = 1'b0;
        m_valid = 1'b0; m_flush = 1'b0; m_pc = '0; after = '0; m_ipc = '0; m_instr = '0;
      end
      rq = !boot && !stop && (drain || !(m_valid && stall));
      chk("m_req",    32'(imem_req),       32'(rq));
      chk("m_addr",   32'(imem_addr),      32'(m_pc));
      chk("m_pc_out", 32'(pc_out),         32'(m_pc));
      chk("m_halted", 32'(halted),         32'(stop));
      chk("m_valid",  32'(instr_valid),    32'(m_valid));
      chk("m_flush",  32'(redirect_flush), 32'(m_flush));
      if (m_valid || !reset) begin
        chk("m_instr",    32'(instr),    32'(m_instr));
        chk("m_instr_pc", 32'(instr_pc), 32'(m_ipc));
      end
      if (reset) begin
        rd = jump | branch;
        tg = jump ? jump_target : branch_addr;
        nflush = 1'b0;
        if (boot) begin
          boot = 1'b0;
        end else if (stop) begin
          if (rd) m_pc = tg;
          if (resume) stop = 1'b0;
        end else if (drain) begin
          if (rd) after = tg;
          if (halt_req) stop_after = 1'b1;
          if (rd || halt_req) begin nflush = 1'b1; m_valid = 1'b0; end
          if (imem_ack) begin drain = 1'b0; m_pc = after; stop = stop_after; end
        end else begin
          if (rd || halt_req) begin
            dest = rd ? tg : m_pc;
            nflush = 1'b1; m_valid = 1'b0;
            if (rq && !imem_ack) begin drain = 1'b1; after = dest; stop_after = halt_req; end
            else begin m_pc = dest; stop = halt_req; end
          end else if (rq && imem_ack) begin
            m_instr = 16'hA000 ^ {6'b0, m_pc};
            m_ipc = m_pc; m_valid = 1'b1; m_pc = m_pc + 10'd1;
          end else if (!stall) begin
            m_valid = 1'b0;
          end
        end
        m_flush = nflush;
      end
    end
  end

  initial begin : stim
    // 1: reset, then ack tied high
    drive(0,0,0,0,0,0,0,0,1);
    chk("t1_rst_pc", 32'(pc_out), 0); chk("t1_rst_req", 32'(imem_req), 0);
    chk("t1_rst_valid", 32'(instr_valid), 0); chk("t1_rst_halted", 32'(halted), 0);
    drive(1,0,0,0,0,0,0,0,1); chk("t1_idle_pc", 32'(pc_out), 0); chk("t1_idle_req", 32'(imem_req), 0);
    drive(1,0,0,0,0,0,0,0,1); chk("t1_f0_pc", 32'(pc_out), 0); chk("t1_f0_req", 32'(imem_req), 1);
    drive(1,0,0,0,0,0,0,0,1); chk("t1_pc1", 32'(pc_out), 1); chk("t1_ipc0", 32'(instr_pc), 0);
    chk("t1_valid", 32'(instr_valid), 1); chk("t1_instr0", 32'(instr), 32'h0000A000);
    drive(1,0,0,0,0,0,0,0,1); chk("t1_pc2", 32'(pc_out), 2); chk("t1_ipc1", 32'(instr_pc), 1);
    drive(1,0,0,0,0,0,0,0,1); chk("t1_pc3", 32'(pc_out), 3); chk("t1_ipc2", 32'(instr_pc), 2);
    drive(1,0,0,0,0,0,0,0,1); chk("t1_pc4", 32'(pc_out), 4);
    // 2: ack withheld at pc=5
    for (int i = 0; i < 3; i++) begin
      drive(1,0,0,0,0,0,0,0,0);
      chk("t2_addr", 32'(imem_addr), 5); chk("t2_req", 32'(imem_req), 1); chk("t2_pc", 32'(pc_out), 5);
    end
    drive(1,0,0,0,0,0,0,0,1); chk("t2_ack_addr", 32'(imem_addr), 5);
    drive(1,0,0,0,0,0,0,0,0); chk("t2_pc6", 32'(pc_out), 6); chk("t2_ipc5", 32'(instr_pc), 5);
    chk("t2_valid", 32'(instr_valid), 1);
    // 3: branch while pc=8 outstanding
    drive(1,0,0,0,0,0,0,0,1);
    drive(1,0,0,0,0,0,0,0,1); chk("t3_pc7", 32'(pc_out), 7);
    drive(1,0,1,10'd40,0,0,0,0,0); chk("t3_addr8", 32'(imem_addr), 8); chk("t3_req", 32'(imem_req), 1);
    drive(1,0,0,0,0,0,0,0,0); chk("t3_disc_addr", 32'(imem_addr), 8); chk("t3_disc_req", 32'(imem_req), 1);
    chk("t3_flush", 32'(redirect_flush), 1); chk("t3_disc_valid", 32'(instr_valid), 0);
    drive(1,0,0,0,0,0,0,0,1); chk("t3_ack_addr", 32'(imem_addr), 8); chk("t3_flush_off", 32'(redirect_flush), 0);
    drive(1,0,0,0,0,0,0,0,0); chk("t3_addr40", 32'(imem_addr), 40); chk("t3_req40", 32'(imem_req), 1);
    chk("t3_valid0", 32'(instr_valid), 0);
    drive(1,0,0,0,0,0,0,0,1); chk("t3_valid0b", 32'(instr_valid), 0);
    drive(1,0,0,0,0,0,0,0,0); chk("t3_ipc40", 32'(instr_pc), 40); chk("t3_valid1", 32'(instr_valid), 1);
    chk("t3_pc41", 32'(pc_out), 41);
    // 4: jump beats branch; PC wraps
    drive(1,0,1,10'd50,1,10'd100,0,0,1);
    drive(1,0,0,0,0,0,0,0,0); chk("t4_pc100", 32'(pc_out), 100); chk("t4_flush", 32'(redirect_flush), 1);
    chk("t4_valid", 32'(instr_valid), 0);
    drive(1,0,0,0,1,10'd1023,0,0,1);
    drive(1,0,0,0,0,0,0,0,1); chk("t4_pc1023", 32'(pc_out), 1023);
    drive(1,0,0,0,0,0,0,0,0); chk("t4_wrap", 32'(pc_out), 0); chk("t4_ipc1023", 32'(instr_pc), 1023);
    chk("t4_instr", 32'(instr), 32'h0000A3FF);
    // 5: halt with ack in the same cycle, then resume
    drive(1,0,0,0,1,10'd12,0,0,1);
    drive(1,0,0,0,0,0,1,0,1); chk("t5_pc12", 32'(pc_out), 12);
    drive(1,0,0,0,0,0,0,0,0); chk("t5_halted", 32'(halted), 1); chk("t5_pc", 32'(pc_out), 12);
    chk("t5_req", 32'(imem_req), 0); chk("t5_flush", 32'(redirect_flush), 1);
    drive(1,0,0,0,0,0,0,0,0); chk("t5_flush_off", 32'(redirect_flush), 0);
    drive(1,0,0,0,0,0,0,1,0); chk("t5_still_halted", 32'(halted), 1);
    drive(1,0,0,0,0,0,0,0,0); chk("t5_resumed", 32'(halted), 0); chk("t5_req12", 32'(imem_req), 1);
    chk("t5_addr12", 32'(imem_addr), 12);
    // 6: stall holds the word; reset during DISCARD
    drive(1,0,0,0,0,0,0,0,1);
    drive(1,1,0,0,0,0,0,0,0); chk("t6_req_stall", 32'(imem_req), 0); chk("t6_ipc", 32'(instr_pc), 12);
    drive(1,1,0,0,0,0,0,0,1); chk("t6_req_ackign", 32'(imem_req), 0); chk("t6_pc13", 32'(pc_out), 13);
    drive(1,1,0,0,0,0,0,0,0); chk("t6_ipc_held", 32'(instr_pc), 12); chk("t6_instr_held", 32'(instr), 32'h0000A00C);
    chk("t6_valid_held", 32'(instr_valid), 1); chk("t6_pc_held", 32'(pc_out), 13);
    drive(1,0,0,0,0,0,0,0,0); chk("t6_unstall_req", 32'(imem_req), 1);
    drive(1,0,1,10'd200,0,0,0,0,0); chk("t6_req", 32'(imem_req), 1);
    drive(1,0,0,0,0,0,0,0,0); chk("t6_disc_addr", 32'(imem_addr), 13); chk("t6_disc_flush", 32'(redirect_flush), 1);
    drive(0,0,0,0,0,0,0,0,0); chk("t6_rst_pc", 32'(pc_out), 0); chk("t6_rst_req", 32'(imem_req), 0);
    chk("t6_rst_valid", 32'(instr_valid), 0); chk("t6_rst_flush", 32'(redirect_flush), 0);
    chk("t6_rst_addr", 32'(imem_addr), 0);
    drive(1,0,0,0,0,0,0,0,0); chk("t6_idle_req", 32'(imem_req), 0);
    // Mixed traffic, checked by the model only
    for (int i = 0; i < 200; i++) begin
      drive(1, $urandom_range(0,3) == 0, $urandom_range(0,7) == 0, 10'($urandom),
            $urandom_range(0,11) == 0, 10'($urandom), $urandom_range(0,15) == 0,
            $urandom_range(0,3) == 0, $urandom_range(0,2) != 0);
    end
    @(negedge clk); #4;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
